// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the decode-stage scoreboard: RISC-V opcode classes,
// the M-unit func7 value and the drain FSM state encoding.
package id_scoreboard_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STYPE = 7'b0100011;
   localparam logic [6:0] OP_BTYPE = 7'b1100011;
   localparam logic [6:0] OP_JTYPE = 7'b1101111;
   localparam logic [6:0] OP_UTYPE = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [6:0] FUNC7_M_UNIT = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2
   } sb_state_t;

endpackage

// File: rtl/id_scoreboard_sb_hazard_check.sv
// Combinational hazard evaluation for the instruction sitting in decode,
// using only the registered pending-write bitmap.
module sb_hazard_check
   import id_scoreboard_pkg::*;
(
   input  logic        id_valid,
   input  logic        id_flush,
   input  logic [6:0]  id_opcode,
   input  logic [6:0]  id_func7,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_wb_reg_file,
   input  logic        id_wb_load,
   input  logic [31:0] busy_map,
   input  logic        at_max,
   input  logic        fsm_idle,
   output logic        long_op,
   output logic        id_stall
);

   logic rs1_used;
   logic rs2_used;
   logic raw;
   logic waw;

   always_comb begin
      long_op  = id_wb_load | ((id_opcode == OP_RTYPE) & (id_func7 == FUNC7_M_UNIT));
      rs1_used = ~((id_opcode == OP_JTYPE) | (id_opcode == OP_UTYPE) | (id_opcode == OP_AUIPC));
      rs2_used = (id_opcode == OP_RTYPE) | (id_opcode == OP_BTYPE) | (id_opcode == OP_STYPE);
      raw      = (rs1_used & (id_rs1 != '0) & busy_map[id_rs1])
               | (rs2_used & (id_rs2 != '0) & busy_map[id_rs2]);
      waw      = id_wb_reg_file & (id_rd != '0) & busy_map[id_rd];
      id_stall = id_valid & ~id_flush & (raw | waw | (long_op & at_max) | ~fsm_idle);
   end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard tracking in-flight long-latency writebacks, with a
// drain handshake for fences/CSR ops and a sticky error on stray writebacks.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   id_valid,
   input  logic                                   id_flush,
   input  logic [6:0]                             id_opcode,
   input  logic [6:0]                             id_func7,
   input  logic [4:0]                             id_rs1,
   input  logic [4:0]                             id_rs2,
   input  logic [4:0]                             id_rd,
   input  logic                                   id_wb_reg_file,
   input  logic                                   id_wb_load,
   input  logic                                   ex_ready,
   input  logic                                   wb_long_valid,
   input  logic [4:0]                             wb_long_rd,
   input  logic                                   drain_req,
   output logic                                   id_stall,
   output logic                                   issue,
   output logic [31:0]                            busy_map,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt,
   output logic                                   drain_ack,
   output logic                                   sb_error
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   sb_state_t   state;
   sb_state_t   state_nxt;
   logic        long_op;
   logic        at_max;
   logic        set_en;
   logic        clr_en;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   assign at_max = (outstanding_cnt == CNT_MAX);

   sb_hazard_check u_hazard (
      .id_valid       (id_valid),
      .id_flush       (id_flush),
      .id_opcode      (id_opcode),
      .id_func7       (id_func7),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_wb_reg_file (id_wb_reg_file),
      .id_wb_load     (id_wb_load),
      .busy_map       (busy_map),
      .at_max         (at_max),
      .fsm_idle       (state == IDLE),
      .long_op        (long_op),
      .id_stall       (id_stall)
   );

   assign issue = id_valid & ~id_flush & ~id_stall & ex_ready;

   always_comb begin
      set_en   = issue & long_op & id_wb_reg_file & (id_rd != '0);
      clr_en   = wb_long_valid & (wb_long_rd != '0) & busy_map[wb_long_rd];
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[id_rd] = 1'b1;
      if (clr_en) clr_mask[wb_long_rd] = 1'b1;
   end

   // Set and clear never target the same register: WAW stalls any issue to a busy rd.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_map <= '0;
      end else begin
         busy_map <= ((busy_map | set_mask) & ~clr_mask) & ~32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding_cnt <= '0;
      end else begin
         case ({set_en, clr_en})
            2'b10:   if (outstanding_cnt != CNT_MAX) outstanding_cnt <= outstanding_cnt + CW'(1);
            2'b01:   if (outstanding_cnt != '0)      outstanding_cnt <= outstanding_cnt - CW'(1);
            default: outstanding_cnt <= outstanding_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_error <= 1'b0;
      end else if (wb_long_valid & ~clr_en) begin
         sb_error <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (drain_req) state_nxt = DRAIN;
         DRAIN:   if (outstanding_cnt == '0) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      drain_ack = (state == ACK);
   end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: a cycle table for hazard/issue/tracking
// behaviour plus hand sequences for reset, drain and stray writebacks.
module tb_id_scoreboard;
   import id_scoreboard_pkg::*;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid, id_flush;
   logic [6:0]  id_opcode, id_func7;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_wb_reg_file, id_wb_load, ex_ready;
   logic        wb_long_valid;
   logic [4:0]  wb_long_rd;
   logic        drain_req;
   logic        id_stall, issue, drain_ack, sb_error;
   logic [31:0] busy_map;
   logic [2:0]  outstanding_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_scoreboard #(.MAX_OUTSTANDING(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_flush        (id_flush),
      .id_opcode       (id_opcode),
      .id_func7        (id_func7),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rd           (id_rd),
      .id_wb_reg_file  (id_wb_reg_file),
      .id_wb_load      (id_wb_load),
      .ex_ready        (ex_ready),
      .wb_long_valid   (wb_long_valid),
      .wb_long_rd      (wb_long_rd),
      .drain_req       (drain_req),
      .id_stall        (id_stall),
      .issue           (issue),
      .busy_map        (busy_map),
      .outstanding_cnt (outstanding_cnt),
      .drain_ack       (drain_ack),
      .sb_error        (sb_error)
   );

   typedef struct {
      logic        valid, flush;
      logic [6:0]  op, f7;
      logic [4:0]  rs1, rs2, rd;
      logic        wbrf, wbld, exr, wbv;
      logic [4:0]  wbrd;
      logic        e_stall, e_issue;
      logic [31:0] e_busy;
      logic [2:0]  e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vecs[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_flush = 0; id_opcode = '0; id_func7 = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_wb_reg_file = 0; id_wb_load = 0;
      ex_ready = 1; wb_long_valid = 0; wb_long_rd = '0;
   endtask

   task automatic instr(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic wbrf, input logic wbld);
      id_valid = 1; id_flush = 0; id_opcode = op; id_func7 = f7;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_wb_reg_file = wbrf; id_wb_load = wbld;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 0;
      #1;
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // lw x5; dependent add stalls until the cycle after the writeback
      vecs[0]  = '{T,F,OP_LOAD, 7'h00,5'd1, 5'd0,5'd5, T,T,T,F,5'd0,  F,T,32'h020,3'd1,F};
      vecs[1]  = '{T,F,OP_RTYPE,7'h00,5'd5, 5'd1,5'd6, T,F,T,F,5'd0,  T,F,32'h020,3'd1,F};
      vecs[2]  = '{T,F,OP_RTYPE,7'h00,5'd5, 5'd1,5'd6, T,F,T,T,5'd5,  T,F,32'h000,3'd0,F};
      vecs[3]  = '{T,F,OP_RTYPE,7'h00,5'd5, 5'd1,5'd6, T,F,T,F,5'd0,  F,T,32'h000,3'd0,F};
      vecs[4]  = '{T,F,OP_RTYPE,7'h00,5'd6, 5'd1,5'd8, T,F,F,F,5'd0,  F,F,32'h000,3'd0,F};
      // four muls fill the tracker; the fifth waits for a retire
      vecs[5]  = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd1, T,F,T,F,5'd0,  F,T,32'h002,3'd1,F};
      vecs[6]  = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd2, T,F,T,F,5'd0,  F,T,32'h006,3'd2,F};
      vecs[7]  = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd3, T,F,T,F,5'd0,  F,T,32'h00E,3'd3,F};
      vecs[8]  = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd4, T,F,T,F,5'd0,  F,T,32'h01E,3'd4,F};
      vecs[9]  = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd7, T,F,T,F,5'd0,  T,F,32'h01E,3'd4,F};
      vecs[10] = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd7, T,F,T,T,5'd2,  T,F,32'h01A,3'd3,F};
      vecs[11] = '{T,F,OP_RTYPE,7'h01,5'd0, 5'd0,5'd7, T,F,T,F,5'd0,  F,T,32'h09A,3'd4,F};
      // retire x1, then lw x9 alongside retire x3
      vecs[12] = '{F,F,7'h00,   7'h00,5'd0, 5'd0,5'd0, F,F,T,T,5'd1,  F,F,32'h098,3'd3,F};
      vecs[13] = '{T,F,OP_LOAD, 7'h00,5'd10,5'd0,5'd9, T,T,T,T,5'd3,  F,T,32'h290,3'd3,F};
      // stray writeback, lw x0, flush, operand-usage rules
      vecs[14] = '{F,F,7'h00,   7'h00,5'd0, 5'd0,5'd0, F,F,T,T,5'd12, F,F,32'h290,3'd3,T};
      vecs[15] = '{T,F,OP_LOAD, 7'h00,5'd1, 5'd0,5'd0, T,T,T,F,5'd0,  F,T,32'h290,3'd3,T};
      vecs[16] = '{T,T,OP_RTYPE,7'h00,5'd4, 5'd7,5'd13,T,F,T,F,5'd0,  F,F,32'h290,3'd3,T};
      vecs[17] = '{T,F,OP_ITYPE,7'h00,5'd1, 5'd4,5'd11,T,F,T,F,5'd0,  F,T,32'h290,3'd3,T};
      vecs[18] = '{T,F,OP_JTYPE,7'h00,5'd9, 5'd7,5'd12,T,F,T,F,5'd0,  F,T,32'h290,3'd3,T};
      vecs[19] = '{T,F,OP_STYPE,7'h00,5'd0, 5'd7,5'd0, F,F,T,F,5'd0,  T,F,32'h290,3'd3,T};
      vecs[20] = '{T,F,OP_ITYPE,7'h00,5'd0, 5'd0,5'd9, T,F,T,F,5'd0,  T,F,32'h290,3'd3,T};
      vecs[21] = '{T,F,OP_ITYPE,7'h00,5'd0, 5'd0,5'd9, F,F,T,F,5'd0,  F,T,32'h290,3'd3,T};
      vecs[22] = '{T,F,OP_RTYPE,7'h00,5'd1, 5'd9,5'd14,T,F,T,F,5'd0,  T,F,32'h290,3'd3,T};
      vecs[23] = '{T,F,OP_UTYPE,7'h00,5'd4, 5'd0,5'd15,T,F,T,F,5'd0,  F,T,32'h290,3'd3,T};

      idle_inputs();
      drain_req = 0;
      #1;
      chk("reset_busy", busy_map, 32'h0);
      chk("reset_cnt", 32'(outstanding_cnt), 32'd0);
      chk("reset_ack", 32'(drain_ack), 32'd0);
      chk("reset_err", 32'(sb_error), 32'd0);
      @(negedge clk);
      rst = 1;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         id_valid = vecs[i].valid; id_flush = vecs[i].flush;
         id_opcode = vecs[i].op; id_func7 = vecs[i].f7;
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
         id_wb_reg_file = vecs[i].wbrf; id_wb_load = vecs[i].wbld; ex_ready = vecs[i].exr;
         wb_long_valid = vecs[i].wbv; wb_long_rd = vecs[i].wbrd;
         #1;
         chk($sformatf("v%0d_stall", i), 32'(id_stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d_issue", i), 32'(issue), 32'(vecs[i].e_issue));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_busy", i), busy_map, vecs[i].e_busy);
         chk($sformatf("v%0d_cnt", i), 32'(outstanding_cnt), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_err", i), 32'(sb_error), 32'(vecs[i].e_err));
      end

      // asynchronous reset with three entries pending, checked before any edge
      @(negedge clk);
      idle_inputs();
      #2;
      rst = 0;
      #1;
      chk("async_busy", busy_map, 32'h0);
      chk("async_cnt", 32'(outstanding_cnt), 32'd0);
      chk("async_err", 32'(sb_error), 32'd0);
      chk("async_ack", 32'(drain_ack), 32'd0);
      @(negedge clk);
      rst = 1;

      // writeback for an entry discarded by reset is an error
      @(negedge clk);
      wb_long_valid = 1; wb_long_rd = 5'd4;
      @(posedge clk);
      #1;
      chk("stale_wb_err", 32'(sb_error), 32'd1);
      chk("stale_wb_cnt", 32'(outstanding_cnt), 32'd0);
      @(negedge clk);
      idle_inputs();
      pulse_reset();

      // drain with two outstanding muls
      instr(OP_RTYPE, FUNC7_M_UNIT, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      @(negedge clk);
      instr(OP_RTYPE, FUNC7_M_UNIT, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
      @(negedge clk);
      idle_inputs();
      chk("drain_cnt2", 32'(outstanding_cnt), 32'd2);
      drain_req = 1;
      @(posedge clk);
      #1;
      chk("drain_enter_ack", 32'(drain_ack), 32'd0);
      @(negedge clk);
      instr(OP_ITYPE, 7'h00, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0);
      #1;
      chk("drain_block_stall", 32'(id_stall), 32'd1);
      chk("drain_block_issue", 32'(issue), 32'd0);
      @(negedge clk);
      wb_long_valid = 1; wb_long_rd = 5'd1;
      @(negedge clk);
      wb_long_rd = 5'd2;
      @(posedge clk);
      #1;
      chk("drain_cnt0", 32'(outstanding_cnt), 32'd0);
      chk("drain_ack_early", 32'(drain_ack), 32'd0);
      @(negedge clk);
      wb_long_valid = 0;
      #1;
      chk("drain_last_stall", 32'(id_stall), 32'd1);
      @(posedge clk);
      #1;
      chk("drain_ack_pulse", 32'(drain_ack), 32'd1);
      @(negedge clk);
      drain_req = 0;
      #1;
      chk("ack_state_stall", 32'(id_stall), 32'd1);
      @(posedge clk);
      #1;
      chk("drain_ack_end", 32'(drain_ack), 32'd0);
      @(negedge clk);
      #1;
      chk("post_drain_issue", 32'(issue), 32'd1);
      chk("drain_err", 32'(sb_error), 32'd0);

      // drain with nothing outstanding still spends one cycle in DRAIN
      @(negedge clk);
      idle_inputs();
      drain_req = 1;
      @(posedge clk);
      #1;
      chk("zdrain_ack0", 32'(drain_ack), 32'd0);
      @(negedge clk);
      drain_req = 0;
      @(posedge clk);
      #1;
      chk("zdrain_ack1", 32'(drain_ack), 32'd1);
      @(posedge clk);
      #1;
      chk("zdrain_ack2", 32'(drain_ack), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, maximum in-flight long-latency writebacks.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 id_valid  input  1  decode holds a valid instruction.
REQ-005 id_flush  input  1  decode instruction killed this cycle.
REQ-006 id_opcode, id_func7  input  7 each  decoded opcode, func7.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  decoded register addresses.
REQ-008 id_wb_reg_file, id_wb_load  input  1 each  instruction writes rd / is a load.
REQ-009 ex_ready  input  1  execute stage accepts an instruction this cycle.
REQ-010 wb_long_valid  input  1; wb_long_rd  input  5  long-latency result retired to register file.
REQ-011 drain_req  input  1  level request to empty all outstanding ops (fence/CSR).
REQ-012 id_stall  output  1  hold decode.
REQ-013 issue  output  1  instruction leaves decode this cycle.
REQ-014 busy_map  output  32  registered pending-write bitmap; bit 0 constant 0.
REQ-015 outstanding_cnt  output  $clog2(MAX_OUTSTANDING+1)  in-flight count.
REQ-016 drain_ack  output  1  one-cycle pulse, drain complete.
REQ-017 sb_error  output  1  sticky: writeback to a non-busy register.

Function
REQ-018 long_op SHALL be id_wb_load, or id_opcode==RTYPE with id_func7==M_UNIT (0000001).
REQ-019 rs1 SHALL count as used except for JTYPE, UTYPE, AUIPC; rs2 used only for RTYPE, BTYPE, STYPE; x0 never hazards.
REQ-020 raw SHALL be any used, nonzero rs with busy_map bit set; waw SHALL be id_wb_reg_file & rd!=0 & busy_map[rd].
REQ-021 id_stall SHALL = id_valid & ~id_flush & (raw | waw | (long_op & count==MAX_OUTSTANDING) | state!=IDLE).
REQ-022 issue SHALL = id_valid & ~id_flush & ~id_stall & ex_ready; combinational, zero latency.
REQ-023 Hazard checks SHALL use registered busy_map only; same-cycle writeback gives no bypass (stall resolves next cycle).
REQ-024 issue & long_op & id_wb_reg_file & rd!=0 SHALL set busy_map[rd] and increment count next edge; long ops to x0 are untracked.
REQ-025 wb_long_valid with busy_map[wb_long_rd] set and rd!=0 SHALL clear the bit and decrement count next edge.
REQ-026 wb_long_valid to a clear bit or x0 SHALL change no state except setting sb_error.
REQ-027 Simultaneous set (rd A) and clear (rd B): both applied, count unchanged.
REQ-028 Count SHALL never exceed MAX_OUTSTANDING nor wrap below 0.
REQ-029 FSM states IDLE, DRAIN, ACK; IDLE->DRAIN on drain_req; DRAIN->ACK when count==0 (checked on registered count); ACK->IDLE unconditionally.
REQ-030 drain_ack SHALL be 1 only in ACK; a drain_req arriving with count==0 still passes DRAIN for one cycle.
REQ-031 id_flush SHALL not cancel already-issued entries.

Reset
REQ-032 rst low SHALL immediately force busy_map=0, count=0, state=IDLE, sb_error=0, drain_ack=0; combinational outputs follow.
REQ-033 Reset mid-operation SHALL discard all pending entries; later writebacks for them set sb_error.

Structure
REQ-034 Opcode, FUNC7_M_UNIT constants and FSM state encoding SHALL live in the shared defines package.
REQ-035 Combinational hazard evaluation (REQ-018..021) SHALL be one sub-module, sb_hazard_check.

Verification
REQ-036 Issue lw x5 (ex_ready=1), then add x6,x5,x1 next cycle -> id_stall=1 until cycle after wb_long_valid rd=5; busy_map[5] 1->0.
REQ-037 Issue 4 mul to x1..x4, 5th mul to x7 -> stall, count=4; retire x2 -> 5th issues next cycle, count stays 4.
REQ-038 Same cycle: issue lw x9 and retire x3 -> busy[9]=1, busy[3]=0, count unchanged.
REQ-039 Two outstanding, drain_req=1 -> all issue blocked; after both retire, drain_ack pulses exactly one cycle, then IDLE.
REQ-040 wb_long_valid rd=12 with busy[12]=0 -> sb_error=1 and stays 1; lw x0 -> busy_map and count unchanged.
REQ-041 rst low with count=3 -> busy_map=0, count=0, IDLE asynchronously, before next clk edge.
